// File: rtl/combo_lock_pkg.sv
// Shared types for the multi-digit combination lock: FSM state enum,
// the status encoding seen by the HEX decoders, and sizing helpers.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        LOCKED,
        ENTERING,
        UNLOCKED,
        ALARM,
        PROG
    } state_e;

    localparam logic [1:0] ST_LOCKED = 2'b00;
    localparam logic [1:0] ST_UNLOCK = 2'b01;
    localparam logic [1:0] ST_ALARM  = 2'b10;
    localparam logic [1:0] ST_PROG   = 2'b11;

    // ENTERING deliberately reports as LOCKED so existing decoders are unchanged.
    function automatic logic [1:0] status_of(state_e s);
        case (s)
            UNLOCKED: return ST_UNLOCK;
            ALARM:    return ST_ALARM;
            PROG:     return ST_PROG;
            default:  return ST_LOCKED;
        endcase
    endfunction

    function automatic int idx_width(int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/combo_lock_seq_if.sv
// User-facing bundle of the combination lock: switch word, pulses and status.
// master = switch/button side, slave = the lock itself.
interface combo_lock_seq_if #(
    parameter int CODE_W    = 10,
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 3
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FC_W  = $clog2(MAX_TRIES + 1);

    logic [CODE_W-1:0] entry;
    logic              enter;
    logic              lock;
    logic              prog;
    logic [1:0]        status;
    logic              entering;
    logic [IDX_W-1:0]  digit_idx;
    logic [FC_W-1:0]   fail_cnt;
    logic              alarm;

    modport master (
        output entry, enter, lock, prog,
        input  status, entering, digit_idx, fail_cnt, alarm
    );

    modport slave (
        input  entry, enter, lock, prog,
        output status, entering, digit_idx, fail_cnt, alarm
    );
endinterface

// File: rtl/lock_alarm_timer.sv
// Loadable down-counter that times the alarm hold period; expire is high
// during the last counted cycle (count == 1).
module lock_alarm_timer #(
    parameter  int ALARM_CYC = 1024,
    localparam int W         = $clog2(ALARM_CYC + 1)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] count_q;

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else if (load)
            count_q <= value;
        else if (count_q != '0)
            count_q <= count_q - W'(1);
    end

    assign expire = (count_q == W'(1));
endmodule

// File: rtl/combo_lock_seq.sv
// Multi-digit combination lock with failure counting and timed alarm.
// Optional code programming is compiled in with COMBO_LOCK_CODE_PROG_EN.
module combo_lock_seq
    import combo_lock_pkg::*;
#(
    parameter int                       CODE_W    = 10,
    parameter int                       DIGITS    = 4,
    parameter int                       MAX_TRIES = 3,
    parameter int                       ALARM_CYC = 1024,
    parameter logic [DIGITS*CODE_W-1:0] CODE_INIT = '0
) (
    input logic             clock,
    input logic             reset_n,
    combo_lock_seq_if.slave bus
);
    localparam int               IDX_W    = idx_width(DIGITS);
    localparam int               FC_W     = $clog2(MAX_TRIES + 1);
    localparam int               TMR_W    = $clog2(ALARM_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [FC_W-1:0]  FAIL_MAX = FC_W'(MAX_TRIES);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         digit_idx_q;
    logic [FC_W-1:0]          fail_cnt_q;
    logic                     mismatch_q;
    logic [1:0]               status_q;
    logic                     entering_q;
    logic                     alarm_q;
    logic [DIGITS*CODE_W-1:0] code;
    logic [CODE_W-1:0]        cur_digit;
    logic                     is_last, mm_any, tries_out;
    logic                     tmr_load, tmr_expire;

`ifdef COMBO_LOCK_CODE_PROG_EN
    logic [DIGITS*CODE_W-1:0] code_q, shadow_q, shadow_d;
    logic                     prog_wr;

    always_comb begin
        shadow_d = shadow_q;
        shadow_d[digit_idx_q*CODE_W +: CODE_W] = bus.entry;
    end

    assign prog_wr = (state_q == PROG) && bus.enter && !bus.lock;

    // NOTE: the code store is reset on purpose: a reset must restore CODE_INIT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_q   <= CODE_INIT;
            shadow_q <= CODE_INIT;
        end else if (prog_wr) begin
            shadow_q <= shadow_d;
            if (digit_idx_q == LAST_IDX)
                code_q <= shadow_d;
        end
    end

    assign code = code_q;
`else
    logic unused_prog;
    assign unused_prog = bus.prog;
    assign code        = CODE_INIT;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        cur_digit = code[digit_idx_q*CODE_W +: CODE_W];
        is_last   = (digit_idx_q == LAST_IDX);
        mm_any    = mismatch_q | (bus.entry != cur_digit);
        tries_out = (int'(fail_cnt_q) + 1) >= MAX_TRIES;
        state_d   = state_q;
        case (state_q)
            LOCKED, ENTERING: begin
                if (bus.lock)
                    state_d = LOCKED;
                else if (bus.enter) begin
                    if (!is_last)      state_d = ENTERING;
                    else if (!mm_any)  state_d = UNLOCKED;
                    else if (tries_out) state_d = ALARM;
                    else               state_d = LOCKED;
                end
            end
            UNLOCKED: begin
                if (bus.lock)
                    state_d = LOCKED;
`ifdef COMBO_LOCK_CODE_PROG_EN
                else if (bus.prog)
                    state_d = PROG;
`endif
            end
            ALARM: if (tmr_expire) state_d = LOCKED;
`ifdef COMBO_LOCK_CODE_PROG_EN
            PROG: begin
                if (bus.lock)
                    state_d = LOCKED;
                else if (bus.enter && is_last)
                    state_d = UNLOCKED;
            end
`endif
            default: state_d = LOCKED;
        endcase
    end

    assign tmr_load = (state_q != ALARM) && (state_d == ALARM);

    lock_alarm_timer #(.ALARM_CYC(ALARM_CYC)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (TMR_W'(ALARM_CYC)),
        .expire  (tmr_expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOCKED;
            digit_idx_q <= '0;
            fail_cnt_q  <= '0;
            mismatch_q  <= 1'b0;
            status_q    <= ST_LOCKED;
            entering_q  <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_of(state_d);
            entering_q <= (state_d == ENTERING);
            alarm_q    <= (state_d == ALARM);
            case (state_q)
                LOCKED, ENTERING: begin
                    if (bus.lock) begin
                        digit_idx_q <= '0;
                        mismatch_q  <= 1'b0;
                    end else if (bus.enter) begin
                        if (!is_last) begin
                            digit_idx_q <= digit_idx_q + IDX_W'(1);
                            mismatch_q  <= mm_any;
                        end else begin
                            digit_idx_q <= '0;
                            mismatch_q  <= 1'b0;
                            if (!mm_any)        fail_cnt_q <= '0;
                            else if (tries_out) fail_cnt_q <= FAIL_MAX;
                            else                fail_cnt_q <= fail_cnt_q + FC_W'(1);
                        end
                    end
                end
                ALARM: if (tmr_expire) fail_cnt_q <= '0;
`ifdef COMBO_LOCK_CODE_PROG_EN
                PROG: begin
                    if (bus.lock || (bus.enter && is_last))
                        digit_idx_q <= '0;
                    else if (bus.enter)
                        digit_idx_q <= digit_idx_q + IDX_W'(1);
                end
`endif
                default: digit_idx_q <= '0;
            endcase
        end
    end

    assign bus.status    = status_q;
    assign bus.entering  = entering_q;
    assign bus.digit_idx = digit_idx_q;
    assign bus.fail_cnt  = fail_cnt_q;
    assign bus.alarm     = alarm_q;
endmodule

// File: tb/tb_combo_lock_seq.sv
// Self-checking bench for combo_lock_seq: directed scenarios plus random
// stimulus, compared every cycle against a queue-based behavioural model.
module tb_combo_lock_seq;
    localparam int CODE_W    = 10;
    localparam int DIGITS    = 4;
    localparam int MAX_TRIES = 3;
    localparam int ALARM_CYC = 8;
    localparam logic [DIGITS*CODE_W-1:0] CODE_INIT = {10'h000, 10'h3FF, 10'h155, 10'h2AA};

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   cmp_en   = 1'b0;

    combo_lock_seq_if #(.CODE_W(CODE_W), .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES)) bus ();

    combo_lock_seq #(
        .CODE_W(CODE_W), .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES),
        .ALARM_CYC(ALARM_CYC), .CODE_INIT(CODE_INIT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Behavioural model: words typed so far, alarm time left, unlocked flag.
    int m_code[DIGITS] = '{'h2AA, 'h155, 'h3FF, 'h000};
    int typed[$];
    int pbuf[$];
    int m_alarm_left = 0;
    int m_fail       = 0;
    bit m_unlocked   = 0;
    bit m_prog       = 0;
`ifdef COMBO_LOCK_CODE_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    function automatic void model_reset();
        m_code       = '{'h2AA, 'h155, 'h3FF, 'h000};
        typed.delete();
        pbuf.delete();
        m_alarm_left = 0;
        m_fail       = 0;
        m_unlocked   = 0;
        m_prog       = 0;
    endfunction

    function automatic void model_step(bit en, bit lk, bit pg, int w);
        bit ok;
        if (m_alarm_left > 0) begin
            m_alarm_left--;
            if (m_alarm_left == 0) m_fail = 0;
        end else if (m_prog) begin
            if (lk) begin
                m_prog = 0; m_unlocked = 0; pbuf.delete();
            end else if (en) begin
                pbuf.push_back(w);
                if (pbuf.size() == DIGITS) begin
                    foreach (m_code[i]) m_code[i] = pbuf[i];
                    pbuf.delete(); m_prog = 0;
                end
            end
        end else if (m_unlocked) begin
            if (lk) m_unlocked = 0;
            else if (pg && PROG_EN) m_prog = 1;
        end else if (lk) begin
            typed.delete();
        end else if (en) begin
            typed.push_back(w);
            if (typed.size() == DIGITS) begin
                ok = 1;
                foreach (m_code[i]) if (typed[i] != m_code[i]) ok = 0;
                if (ok) begin
                    m_unlocked = 1; m_fail = 0;
                end else if (m_fail + 1 >= MAX_TRIES) begin
                    m_fail = MAX_TRIES; m_alarm_left = ALARM_CYC;
                end else
                    m_fail++;
                typed.delete();
            end
        end
    endfunction

    function automatic int exp_status();
        if (m_alarm_left > 0) return 2;
        if (m_prog)           return 3;
        if (m_unlocked)       return 1;
        return 0;
    endfunction

    function automatic int exp_idx();
        return m_prog ? pbuf.size() : typed.size();
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        if (cmp_en && reset_n) begin
            check("cyc_status",   int'(bus.status),    exp_status());
            check("cyc_entering", int'(bus.entering),  int'(exp_status() == 0 && typed.size() > 0));
            check("cyc_idx",      int'(bus.digit_idx), exp_idx());
            check("cyc_fail",     int'(bus.fail_cnt),  m_fail);
            check("cyc_alarm",    int'(bus.alarm),     int'(m_alarm_left > 0));
        end
    end

    task automatic step(input bit en, input bit lk, input bit pg, input int w);
        @(negedge clock);
        bus.enter = en; bus.lock = lk; bus.prog = pg; bus.entry = CODE_W'(w);
        @(posedge clock);
        model_step(en, lk, pg, w);
        #1;
        bus.enter = 1'b0; bus.lock = 1'b0; bus.prog = 1'b0;
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d);
        step(1, 0, 0, a); step(1, 0, 0, b); step(1, 0, 0, c); step(1, 0, 0, d);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check({tag, "_status"},   int'(bus.status),    0);
        check({tag, "_entering"}, int'(bus.entering),  0);
        check({tag, "_idx"},      int'(bus.digit_idx), 0);
        check({tag, "_fail"},     int'(bus.fail_cnt),  0);
        check({tag, "_alarm"},    int'(bus.alarm),     0);
        model_reset();
        @(negedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_alarm;
        reset_n = 1'b0;
        bus.entry = '0; bus.enter = 1'b0; bus.lock = 1'b0; bus.prog = 1'b0;
        #8;
        check("rst_status", int'(bus.status), 0);
        check("rst_alarm",  int'(bus.alarm),  0);
        check("rst_idx",    int'(bus.digit_idx), 0);
        #4 reset_n = 1'b1;
        cmp_en = 1'b1;

        // Correct code unlocks one cycle after the 4th enter.
        enter_code('h2AA, 'h155, 'h3FF, 'h000);
        check("ok_status",   int'(bus.status),   1);
        check("ok_fail",     int'(bus.fail_cnt), 0);
        check("ok_entering", int'(bus.entering), 0);
        step(0, 0, 1, 0);
`ifndef COMBO_LOCK_CODE_PROG_EN
        check("prog_ignored", int'(bus.status), 1);
`else
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
`endif
        step(0, 1, 0, 0);
        check("relock", int'(bus.status), 0);

        // Wrong second digit: no early reveal, then one failure.
        step(1, 0, 0, 'h2AA); check("bad_ent1", int'(bus.entering), 1);
        step(1, 0, 0, 'h154); check("bad_ent2", int'(bus.entering), 1);
        step(1, 0, 0, 'h3FF); check("bad_ent3", int'(bus.entering), 1);
        step(1, 0, 0, 'h000);
        check("bad_status", int'(bus.status),   0);
        check("bad_fail",   int'(bus.fail_cnt), 1);

        // Abort with enter+lock together after two good digits.
        step(1, 0, 0, 'h2AA); step(1, 0, 0, 'h155);
        step(1, 1, 0, 'h3FF);
        check("abort_status", int'(bus.status),    0);
        check("abort_idx",    int'(bus.digit_idx), 0);
        check("abort_fail",   int'(bus.fail_cnt),  1);

        // Clear failures, then three wrong sequences trip the alarm.
        enter_code('h2AA, 'h155, 'h3FF, 'h000);
        step(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) enter_code('h001, 'h155, 'h3FF, 'h000);
        check("alarm_status", int'(bus.status),   2);
        check("alarm_fail",   int'(bus.fail_cnt), 3);
        n_alarm = bus.alarm ? 1 : 0;
        for (int k = 0; k < 11; k++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), CODE_INIT[9:0]);
            if (bus.alarm) n_alarm++;
        end
        check("alarm_cycles", n_alarm, 8);
        check("post_alarm_status", int'(bus.status),   0);
        check("post_alarm_fail",   int'(bus.fail_cnt), 0);

`ifdef COMBO_LOCK_CODE_PROG_EN
        // Program a new code, verify old fails and new unlocks.
        enter_code('h2AA, 'h155, 'h3FF, 'h000);
        step(0, 0, 1, 0);
        check("prog_status", int'(bus.status), 3);
        enter_code('h001, 'h002, 'h003, 'h004);
        check("prog_done", int'(bus.status), 1);
        step(0, 1, 0, 0);
        enter_code('h2AA, 'h155, 'h3FF, 'h000);
        check("old_fails", int'(bus.status), 0);
        enter_code('h001, 'h002, 'h003, 'h004);
        check("new_unlocks", int'(bus.status), 1);
        step(0, 0, 1, 0);
        step(1, 0, 0, 'h111); step(1, 0, 0, 'h222);
        step(0, 1, 0, 0);
        check("prog_abort", int'(bus.status), 0);
        enter_code('h001, 'h002, 'h003, 'h004);
        check("kept_code", int'(bus.status), 1);
        step(0, 1, 0, 0);
`endif

        // Async reset mid-alarm and mid-sequence.
        for (int k = 0; k < 3; k++) enter_code('h3FF, 'h3FF, 'h3FF, 'h3FF);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        async_reset("rst_alarm");
        step(1, 0, 0, 'h2AA); step(1, 0, 0, 'h155);
        async_reset("rst_seq");
        enter_code('h2AA, 'h155, 'h3FF, 'h000);
        check("init_code_back", int'(bus.status), 1);

        // Random traffic, biased towards the right digits.
        for (int k = 0; k < 400; k++) begin
            int w;
            if (m_alarm_left == 0 && !m_unlocked && !m_prog && $urandom_range(0, 3) != 0)
                w = m_code[typed.size()];
            else
                w = $urandom_range(0, 1023);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, w);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/combo_lock_seq.md
Name: combo_lock_seq

Overview:
- Parametrised multi-digit combination lock FSM; successor to the single-word switch lock.
- The user enters a code of DIGITS words one at a time from the switch bank. Each word is sampled on an `enter` pulse.
- Repeated failures trip a timed alarm.
- `status[1:0]` keeps the existing LOCKED/UNLOCK/ALARM encoding, so the existing HEX display decoders attach unchanged.

Parameters:
- CODE_W, 10, width of one code word (switch bank width).
- DIGITS, 4, number of words in the code; minimum 1.
- MAX_TRIES, 3, consecutive failed sequences before alarm; minimum 1.
- ALARM_CYC, 1024, clock cycles the alarm is held; minimum 1.
- CODE_INIT, DIGITS*CODE_W bits, reset code; digit i is bits [i*CODE_W +: CODE_W].

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- entry  in  CODE_W  current switch word.
- enter  in  1  synchronous single-cycle pulse; samples entry.
- lock  in  1  synchronous single-cycle pulse; relock or abort.
- prog  in  1  enters code programming; ignored unless CODE_PROG_EN is defined.
- status  out  2  00 LOCKED (incl. entering), 01 UNLOCKED, 10 ALARM, 11 PROG.
- entering  out  1  high while a sequence is partially entered.
- digit_idx  out  max(1,$clog2(DIGITS))  index of the next digit expected.
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures.
- alarm  out  1  high in ALARM.

Behaviour:
- Reset (reset_n low, async) forces:
  - state LOCKED, digit_idx 0, fail_cnt 0, mismatch flag 0, alarm 0, entering 0, timer 0;
  - stored code = CODE_INIT.
- Registered outputs: all outputs reflect the state one cycle after the triggering pulse.
- LOCKED:
  - enter compares entry with digit 0 and sets mismatch = (entry != digit 0).
  - If DIGITS==1, evaluate immediately (see below); otherwise go to ENTERING with digit_idx=1.
- ENTERING (status 00, entering 1):
  - enter compares entry with digit[digit_idx]; mismatch |= (entry != digit[digit_idx]); digit_idx++.
  - No early abort on a mismatch: the result is revealed only after the last digit.
- Evaluation, on the enter of digit DIGITS-1:
  - No mismatch: go to UNLOCKED, fail_cnt=0.
  - Mismatch and fail_cnt+1 < MAX_TRIES: go to LOCKED, fail_cnt++.
  - Mismatch and fail_cnt+1 == MAX_TRIES: go to ALARM, fail_cnt=MAX_TRIES, timer=ALARM_CYC.
  - In every case digit_idx=0 and mismatch=0.
- lock during ENTERING aborts to LOCKED: digit_idx=0, mismatch=0, fail_cnt unchanged, not counted as a failure.
- UNLOCKED:
  - lock goes to LOCKED.
  - enter is ignored.
  - prog goes to PROG when the feature is enabled.
- ALARM:
  - enter, lock and prog are ignored.
  - timer decrements every cycle; the cycle timer==1 transitions to LOCKED with fail_cnt=0.
  - alarm is high for exactly ALARM_CYC cycles.
- Simultaneous enter and lock in one cycle: lock wins; enter is discarded.
- Simultaneous prog and lock in UNLOCKED: lock wins.
- digit_idx never exceeds DIGITS-1; it wraps to 0 on evaluation or abort.
- Reset asserted mid-sequence or mid-alarm returns everything, including the stored code, to reset values.

Optional Feature:
- Macro: COMBO_LOCK_CODE_PROG_EN.
- Defined:
  - prog in UNLOCKED enters PROG (status 11), digit_idx=0.
  - Each enter writes entry into digit[digit_idx] of a shadow register and increments digit_idx.
  - After digit DIGITS-1, the shadow copies to the active code and the block goes to UNLOCKED.
  - lock in PROG discards the shadow and goes to LOCKED with the old code kept.
- Undefined: prog is ignored, PROG is unreachable, and the code is constant CODE_INIT (no storage flops).

Decomposition:
- Package combo_lock_pkg holds:
  - the state enum (LOCKED, ENTERING, UNLOCKED, ALARM, PROG);
  - status encoding constants ST_LOCKED=2'b00, ST_UNLOCK=2'b01, ST_ALARM=2'b10, ST_PROG=2'b11.
- One sub-module, lock_alarm_timer:
  - loadable down-counter of width $clog2(ALARM_CYC+1);
  - load/value inputs, expire output;
  - async active-low reset.

Test Plan (CODE_W=10, DIGITS=4, MAX_TRIES=3, ALARM_CYC=8, CODE_INIT digits 0x2AA,0x155,0x3FF,0x000):
- Correct sequence 0x2AA,0x155,0x3FF,0x000 -> status 01 one cycle after the 4th enter; fail_cnt 0; entering 0.
- Wrong second digit (0x2AA,0x154,0x3FF,0x000) -> entering stays 1 through all four entries, then status 00 with fail_cnt 1.
- Three wrong sequences -> status 10 and alarm high for exactly 8 cycles; enter/lock ignored throughout; then status 00 with fail_cnt 0.
- Two correct digits, then enter and lock asserted in the same cycle -> abort to status 00, digit_idx 0, fail_cnt unchanged.
- reset_n pulsed low mid-alarm and mid-sequence (asynchronously, between clock edges) -> all outputs return to reset values immediately.
- COMBO_LOCK_CODE_PROG_EN: unlock, prog, program 0x001,0x002,0x003,0x004, lock -> old code now fails and new code unlocks. Repeat with lock mid-PROG -> old code still unlocks.
